// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Round-robin read controller in front of a single-port synchronous ROM.
// Two clients post burst requests (base address, length-1). One burst is
// granted at a time. Consecutive ROM addresses are streamed at one word per
// cycle, and the returned words are tagged with the owning requester.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no burst in flight; requests are sampled and arbitrated here
// BURST | ROM read enable high; address walks from base for len+1 words
// DRAIN | read enable low; the final ROM word is on the response bus
//
// Requests are only looked at in IDLE. A requester therefore has the whole
// BURST/DRAIN window after its ack to drop or change its request. The extra
// IDLE cycle between bursts is deliberate: it keeps the arbiter a plain
// registered decision with no look-ahead.

module rom_read_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_0,
    input  logic [ADDR_W-1:0] base_0,
    input  logic [ADDR_W-1:0] len_0,
    output logic              ack_0,

    input  logic              req_1,
    input  logic [ADDR_W-1:0] base_1,
    input  logic [ADDR_W-1:0] len_1,
    output logic              ack_1,

    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,

    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_id,
    output logic              rd_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              prio;
    logic              owner;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] cnt;

    logic              grant_any;
    logic              grant_id;
    logic [ADDR_W-1:0] grant_base;
    logic [ADDR_W-1:0] grant_len;

    // Arbitration: a lone request wins outright, a tie goes to prio.
    always_comb begin
        grant_any  = req_0 | req_1;
        grant_id   = 1'b0;
        if (req_0 && req_1) begin
            grant_id = prio;
        end else if (req_1) begin
            grant_id = 1'b1;
        end
        grant_base = grant_id ? base_1 : base_0;
        grant_len  = grant_id ? len_1  : len_0;
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            cur       <= '0;
            cnt       <= '0;
            ack_0     <= 1'b0;
            ack_1     <= 1'b0;
            rom_rd_en <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack_0    <= 1'b0;
            ack_1    <= 1'b0;
            // The ROM answers one cycle after the enable, so the response
            // qualifiers are simply the request-side view delayed by one.
            rd_valid <= rom_rd_en;
            rd_last  <= (state == BURST) && (cnt == '0);

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ack_0     <= ~grant_id;
                        ack_1     <= grant_id;
                        owner     <= grant_id;
                        prio      <= ~grant_id;
                        cur       <= grant_base;
                        cnt       <= grant_len;
                        rom_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= BURST;
                    end
                end

                BURST: begin
                    if (cnt != '0) begin
                        // Address wraps naturally at the ROM depth.
                        cur <= cur + ADDR_W'(1);
                        cnt <= cnt - ADDR_W'(1);
                    end else begin
                        rom_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    rom_rd_en <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr = cur;
    assign rd_id    = owner;
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural ROM
// (word[a] = 16'hA000 | a) and a response scoreboard.

module tb_rom_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_0, req_1;
    logic [3:0]  base_0, base_1, len_0, len_1;
    logic        ack_0, ack_1;
    logic        rom_rd_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = 16'h5A5A;
    logic [15:0] rd_data;
    logic        rd_valid, rd_id, rd_last, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        id;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    rom_read_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_0     (req_0),
        .base_0    (base_0),
        .len_0     (len_0),
        .ack_0     (ack_0),
        .req_1     (req_1),
        .base_1    (base_1),
        .len_1     (len_1),
        .ack_1     (ack_1),
        .rom_rd_en (rom_rd_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle registered read
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= 16'hA000 | {12'h000, rom_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input logic id, input logic [3:0] base, input logic [3:0] len);
        exp_t e;
        logic [3:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a      = base + 4'(i);
            e.data = 16'hA000 | {12'h000, a};
            e.id   = id;
            e.last = (i == int'(len));
            exp_q.push_back(e);
        end
    endtask

    // Waits (bounded) for the next ack; cyc = negedges waited.
    task automatic wait_ack(output int who, output int cyc);
        who = -1;
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack_0 || ack_1) begin
                who = ack_0 ? 0 : 1;
                break;
            end
        end
        chk("ack_seen", 32'(who >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    // Response scoreboard and ack exclusivity monitor
    always @(negedge clk) begin
        exp_t e;
        if (ack_0 || ack_1) chk("ack_exclusive", 32'(ack_0 & ack_1), 32'd0);
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_id",   32'(rd_id),   32'(e.id));
                chk("rd_last", 32'(rd_last), 32'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, cyc, run;

        rst_n  = 1'b0;
        req_0  = 1'b0;  req_1  = 1'b0;
        base_0 = 4'd0;  base_1 = 4'd0;
        len_0  = 4'd0;  len_1  = 4'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack_0",  32'(ack_0), 32'd0);
        chk("rst_ack_1",  32'(ack_1), 32'd0);
        chk("rst_rd_en",  32'(rom_rd_en), 32'd0);
        chk("rst_addr",   32'(rom_addr), 32'd0);
        chk("rst_valid",  32'(rd_valid), 32'd0);
        chk("rst_id",     32'(rd_id), 32'd0);
        chk("rst_last",   32'(rd_last), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h5A5A);

        // Tie and round-robin: both held, grant order 0,1,0,1, one idle cycle between
        rst_n  = 1'b1;
        req_0  = 1'b1;  base_0 = 4'd2;  len_0 = 4'd1;
        req_1  = 1'b1;  base_1 = 4'd9;  len_1 = 4'd1;
        push_burst(1'b0, 4'd2, 4'd1);
        push_burst(1'b1, 4'd9, 4'd1);
        push_burst(1'b0, 4'd2, 4'd1);
        push_burst(1'b1, 4'd9, 4'd1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, cyc);
            chk("rr_order", 32'(who), 32'(k % 2));
            if (k == 0) chk("rr_first_latency", 32'(cyc), 32'd1);
            else        chk("rr_gap", 32'(cyc), 32'd4);
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        wait_idle();
        chk("rr_drained", 32'(exp_q.size()), 32'd0);

        // Single word
        req_0 = 1'b1;  base_0 = 4'd3;  len_0 = 4'd0;
        push_burst(1'b0, 4'd3, 4'd0);
        wait_ack(who, cyc);
        req_0 = 1'b0;
        chk("single_who", 32'(who), 32'd0);
        chk("single_latency", 32'(cyc), 32'd1);
        chk("single_rd_en", 32'(rom_rd_en), 32'd1);
        chk("single_addr", 32'(rom_addr), 32'd3);
        chk("single_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_ack_pulse", 32'(ack_0), 32'd0);
        chk("single_valid", 32'(rd_valid), 32'd1);
        chk("single_last", 32'(rd_last), 32'd1);
        chk("single_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_busy2", 32'(busy), 32'd0);
        chk("single_valid_off", 32'(rd_valid), 32'd0);

        // Burst with address wrap: 14,15,0,1
        req_1 = 1'b1;  base_1 = 4'd14;  len_1 = 4'd3;
        push_burst(1'b1, 4'd14, 4'd3);
        wait_ack(who, cyc);
        req_1 = 1'b0;
        chk("wrap_who", 32'(who), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_rd_en", 32'(rom_rd_en), 32'd1);
            chk("wrap_addr", 32'(rom_addr), 32'((14 + i) % 16));
            @(negedge clk);
        end
        chk("wrap_rd_en_off", 32'(rom_rd_en), 32'd0);
        wait_idle();

        // Maximum length: 16 back-to-back words
        req_0 = 1'b1;  base_0 = 4'd0;  len_0 = 4'd15;
        push_burst(1'b0, 4'd0, 4'd15);
        wait_ack(who, cyc);
        req_0 = 1'b0;
        chk("maxlen_who", 32'(who), 32'd0);
        run = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (rd_valid) run++;
        end
        chk("maxlen_valid_run", 32'(run), 32'd16);
        @(negedge clk);
        chk("maxlen_valid_end", 32'(rd_valid), 32'd0);
        wait_idle();

        // Late request during req_0's burst: grant lands on edge N+2
        req_0 = 1'b1;  base_0 = 4'd5;  len_0 = 4'd3;
        push_burst(1'b0, 4'd5, 4'd3);
        push_burst(1'b1, 4'd7, 4'd0);
        wait_ack(who, cyc);
        req_0 = 1'b0;
        chk("late_first_who", 32'(who), 32'd0);
        @(negedge clk);
        req_1 = 1'b1;  base_1 = 4'd7;  len_1 = 4'd0;
        wait_ack(who, cyc);
        req_1 = 1'b0;
        chk("late_who", 32'(who), 32'd1);
        chk("late_grant_gap", 32'(cyc + 1), 32'd6);
        wait_idle();
        chk("late_drained", 32'(exp_q.size()), 32'd0);

        // Reset on the 3rd word of an 8-word burst
        req_0 = 1'b1;  base_0 = 4'd8;  len_0 = 4'd7;
        push_burst(1'b0, 4'd8, 4'd7);
        wait_ack(who, cyc);
        req_0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b0;
        req_0  = 1'b1;  base_0 = 4'd1;  len_0 = 4'd0;
        req_1  = 1'b1;  base_1 = 4'd4;  len_1 = 4'd0;
        @(negedge clk);
        chk("mid_rst_rd_en", 32'(rom_rd_en), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_last",  32'(rd_last), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_addr",  32'(rom_addr), 32'd0);
        chk("mid_rst_id",    32'(rd_id), 32'd0);
        chk("mid_rst_ack",   32'({ack_1, ack_0}), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'(rom_data));
        chk("mid_rst_words_delivered", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        push_burst(1'b0, 4'd1, 4'd0);
        push_burst(1'b1, 4'd4, 4'd0);
        rst_n = 1'b1;
        wait_ack(who, cyc);
        req_0 = 1'b0;
        chk("post_rst_who", 32'(who), 32'd0);
        chk("post_rst_latency", 32'(cyc), 32'd1);
        wait_ack(who, cyc);
        req_1 = 1'b0;
        chk("post_rst_second_who", 32'(who), 32'd1);
        chk("post_rst_gap", 32'(cyc), 32'd3);
        wait_idle();
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
